jtframe_dwnld_mux: RTL and testbench

- Parametrised successor to the fixed MiSTer download splitter.
- Sits between hps_io's ioctl byte stream and the SDRAM programming path.
- Routes each HPS download by index to one of: ROM stream, core_mod register, DIP register, or NVRAM window.
- Decouples the ROM stream through a byte FIFO with hps_wait back-pressure, so the SDRAM side can stall without dropping bytes.

---
 rtl/jtframe_dwnld_mux.sv | 163 ++++++++++++++++
 tb/tb_jtframe_dwnld_mux.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_dwnld_mux.sv
// Routes HPS downloads by index to a ROM byte FIFO, core_mod/dipsw registers or an NVRAM window.
// Latency: ROM bytes appear at the FIFO head 1 cycle after hps_wr; config/NVRAM registers update 1 cycle after hps_wr.
// Backpressure: hps_wait is registered and rises when the FIFO holds DEPTH-1 bytes. Optional macro: JTFRAME_DWNLD_CHKSUM_EN.
module jtframe_dwnld_mux #(
    parameter int              AW          = 27,
    parameter int              DEPTH       = 4,
    parameter int              DIPW        = 32,
    parameter logic [DIPW-1:0] DIP_DEFAULT = '0,
    parameter logic [7:0]      ROM_IDX     = 8'd0,
    parameter logic [7:0]      MOD_IDX     = 8'd1,
    parameter logic [7:0]      DIP_IDX     = 8'd254,
    parameter logic [7:0]      NVRAM_IDX   = 8'd255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hps_download,
    input  logic [7:0]      hps_index,
    input  logic            hps_wr,
    input  logic [AW-1:0]   hps_addr,
    input  logic [7:0]      hps_dout,
    output logic            hps_wait,
    output logic            ioctl_rom_wr,
    input  logic            rom_ack,
    output logic [AW-1:0]   ioctl_addr,
    output logic [7:0]      ioctl_dout,
    output logic            ioctl_ram,
    output logic            downloading,
    output logic [6:0]      core_mod,
    output logic [DIPW-1:0] dipsw,
    output logic            overflow
`ifdef JTFRAME_DWNLD_CHKSUM_EN
    ,
    output logic [15:0]     chksum,
    output logic            chksum_vld
`endif
);
    localparam int PW   = $clog2(DEPTH);
    localparam int DIPB = DIPW / 8;

    typedef enum logic [2:0] {ST_IDLE, ST_ROM, ST_CFG, ST_NVRAM, ST_DRAIN} state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    dat;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW:0]   wr_ptr, rd_ptr, cnt, cnt_nxt;
    logic          fifo_empty, fifo_full, push_req, push, pop;
    logic [AW-1:0] nv_addr;
    logic [7:0]    nv_dat;
    logic [7:0]    idx;
    logic          armed, start;
    state_t        state;

    assign cnt        = wr_ptr - rd_ptr;
    assign fifo_empty = (cnt == '0);
    assign fifo_full  = (cnt == (PW+1)'(DEPTH));
    assign pop        = rom_ack && !fifo_empty;
    assign push_req   = (state == ST_ROM) && hps_wr;
    // a full FIFO can still take a byte when the head leaves in the same cycle
    assign push       = push_req && (!fifo_full || pop);
    assign cnt_nxt    = cnt + (PW+1)'(push) - (PW+1)'(pop);
    assign head       = mem[rd_ptr[PW-1:0]];

    assign ioctl_rom_wr = !fifo_empty;
    assign ioctl_addr   = fifo_empty ? nv_addr : head.addr;
    assign ioctl_dout   = fifo_empty ? nv_dat  : head.dat;

    // armed needs hps_download low first, so a level left high across reset or DRAIN is not a fresh start
    assign start = (state == ST_IDLE) && hps_download && armed;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= '{addr: hps_addr, dat: hps_dout};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            hps_wait <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push_req && fifo_full && !pop) overflow <= 1'b1;
            hps_wait <= (cnt_nxt >= (PW+1)'(DEPTH-1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            armed       <= 1'b0;
            downloading <= 1'b0;
            ioctl_ram   <= 1'b0;
            core_mod    <= '0;
            dipsw       <= DIP_DEFAULT;
            nv_addr     <= '0;
            nv_dat      <= '0;
        end else begin
            if (!hps_download) armed <= 1'b1;
            case (state)
                ST_IDLE: if (start) begin
                    armed <= 1'b0;
                    idx   <= hps_index;
                    if (hps_index == ROM_IDX) begin
                        state       <= ST_ROM;
                        downloading <= 1'b1;
                    end else if (hps_index == NVRAM_IDX) begin
                        state     <= ST_NVRAM;
                        ioctl_ram <= 1'b1;
                    end else begin
                        state <= ST_CFG;
                    end
                end
                ST_ROM: if (!hps_download) state <= ST_DRAIN;
                ST_DRAIN: if (fifo_empty) begin
                    state       <= ST_IDLE;
                    downloading <= 1'b0;
                end
                ST_CFG: begin
                    if (hps_wr && idx == MOD_IDX && hps_addr == '0) core_mod <= hps_dout[6:0];
                    if (hps_wr && idx == DIP_IDX) begin
                        for (int i = 0; i < DIPB; i++) begin
                            if (hps_addr == AW'(i)) dipsw[8*i +: 8] <= hps_dout;
                        end
                    end
                    if (!hps_download) state <= ST_IDLE;
                end
                ST_NVRAM: begin
                    if (hps_wr) begin
                        nv_addr <= hps_addr;
                        nv_dat  <= hps_dout;
                    end
                    if (!hps_download) begin
                        state     <= ST_IDLE;
                        ioctl_ram <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef JTFRAME_DWNLD_CHKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            chksum     <= '0;
            chksum_vld <= 1'b0;
        end else if (start && hps_index == ROM_IDX) begin
            chksum     <= '0;
            chksum_vld <= 1'b0;
        end else begin
            if (pop) chksum <= chksum + {8'd0, head.dat};
            if (state == ST_DRAIN && fifo_empty) chksum_vld <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_jtframe_dwnld_mux.sv
// Bench for jtframe_dwnld_mux: ROM stream, back-pressure, overflow, config, NVRAM and reset-abort.
module tb_jtframe_dwnld_mux;
    localparam int AW = 27;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hps_download = 1'b0;
    logic [7:0]    hps_index = '0;
    logic          hps_wr = 1'b0;
    logic [AW-1:0] hps_addr = '0;
    logic [7:0]    hps_dout = '0;
    logic          hps_wait, ioctl_rom_wr, ioctl_ram, downloading, overflow;
    logic          rom_ack = 1'b0;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic [6:0]    core_mod;
    logic [31:0]   dipsw;
`ifdef JTFRAME_DWNLD_CHKSUM_EN
    logic [15:0]   chksum;
    logic          chksum_vld;
`endif

    jtframe_dwnld_mux dut (
        .clk(clk), .rst(rst), .hps_download(hps_download), .hps_index(hps_index),
        .hps_wr(hps_wr), .hps_addr(hps_addr), .hps_dout(hps_dout), .hps_wait(hps_wait),
        .ioctl_rom_wr(ioctl_rom_wr), .rom_ack(rom_ack), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_ram(ioctl_ram), .downloading(downloading),
        .core_mod(core_mod), .dipsw(dipsw), .overflow(overflow)
`ifdef JTFRAME_DWNLD_CHKSUM_EN
        , .chksum(chksum), .chksum_vld(chksum_vld)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    bit wait_seen = 1'b0;
    logic [AW+7:0] sb [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] idx);
        hps_index    = idx;
        hps_download = 1'b1;
        tick();
        tick();
    endtask

    task automatic wr_byte(input logic [AW-1:0] a, input logic [7:0] d, input bit keep);
        hps_addr = a;
        hps_dout = d;
        hps_wr   = 1'b1;
        if (keep) sb.push_back({a, d});
        tick();
        hps_wr = 1'b0;
    endtask

    task automatic wr_honour(input logic [AW-1:0] a, input logic [7:0] d);
        int n = 0;
        while (hps_wait && n < 50) begin
            tick();
            n++;
        end
        check("wait_timeout", {63'd0, hps_wait}, 64'd0);
        wr_byte(a, d, 1'b1);
    endtask

    task automatic finish_rom();
        int n = 0;
        hps_download = 1'b0;
        tick();
        while (downloading && n < 100) begin
            tick();
            n++;
        end
        check("drain_done", {63'd0, downloading}, 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    // every accepted head byte must match the oldest expected byte
    always @(negedge clk) begin
        if (!rst && hps_wait) wait_seen = 1'b1;
        if (!rst && ioctl_rom_wr && rom_ack) begin
            pops++;
            if (sb.size() == 0) begin
                check("sb_extra_pop", 64'd1, 64'd0);
            end else begin
                logic [AW+7:0] e;
                e = sb.pop_front();
                check("rom_addr", 64'(ioctl_addr), 64'(e[AW+7:8]));
                check("rom_dout", 64'(ioctl_dout), 64'(e[7:0]));
            end
        end
    end

    initial begin
        tick();
        tick();
        check("rst_wait", 64'(hps_wait), 64'd0);
        check("rst_rom_wr", 64'(ioctl_rom_wr), 64'd0);
        check("rst_ram", 64'(ioctl_ram), 64'd0);
        check("rst_dl", 64'(downloading), 64'd0);
        check("rst_addr", 64'(ioctl_addr), 64'd0);
        check("rst_dout", 64'(ioctl_dout), 64'd0);
        check("rst_mod", 64'(core_mod), 64'd0);
        check("rst_dip", 64'(dipsw), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        rst = 1'b0;
        tick();

        // streaming ROM load with downstream always ready
        rom_ack   = 1'b1;
        wait_seen = 1'b0;
        pops      = 0;
        start(8'd0);
        check("rom_dl_up", 64'(downloading), 64'd1);
        for (int i = 0; i < 16; i++) wr_byte(AW'(i), 8'(i), 1'b1);
        finish_rom();
        check("rom_pops", 64'(pops), 64'd16);
        check("rom_no_wait", 64'(wait_seen), 64'd0);
`ifdef JTFRAME_DWNLD_CHKSUM_EN
        check("chksum", 64'(chksum), 64'h78);
        check("chksum_vld", 64'(chksum_vld), 64'd1);
`endif

        // back-pressure, honoured by the sender
        rom_ack = 1'b0;
        start(8'd0);
        for (int i = 0; i < 3; i++) begin
            wr_byte(AW'(32'h100 + i), 8'(8'h40 + i), 1'b1);
            check("bp_wait", 64'(hps_wait), (i >= 2) ? 64'd1 : 64'd0);
        end
        check("bp_rom_wr", 64'(ioctl_rom_wr), 64'd1);
        rom_ack = 1'b1;
        wr_honour(AW'(32'h103), 8'h43);
        wr_honour(AW'(32'h104), 8'h44);
        finish_rom();
        check("bp_ovf", 64'(overflow), 64'd0);

        // overflow: hps_wait ignored, fifth byte dropped
        rom_ack = 1'b0;
        start(8'd0);
        for (int i = 0; i < 5; i++) wr_byte(AW'(32'h200 + i), 8'(8'hA0 + i), i < 4);
        check("ovf_set", 64'(overflow), 64'd1);
        rom_ack = 1'b1;
        finish_rom();
        check("ovf_sticky", 64'(overflow), 64'd1);
`ifdef JTFRAME_DWNLD_CHKSUM_EN
        check("ovf_chksum", 64'(chksum), 64'(16'hA0 + 16'hA1 + 16'hA2 + 16'hA3));
`endif

        // DIP switches and core mode
        start(8'd254);
        wr_byte(AW'(0), 8'hAA, 1'b0);
        wr_byte(AW'(1), 8'h55, 1'b0);
        wr_byte(AW'(2), 8'h12, 1'b0);
        wr_byte(AW'(3), 8'h34, 1'b0);
        wr_byte(AW'(4), 8'h99, 1'b0);
        hps_download = 1'b0;
        tick();
        check("dipsw", 64'(dipsw), 64'h3412_55AA);
        check("cfg_rom_wr", 64'(ioctl_rom_wr), 64'd0);
        tick();
        start(8'd1);
        wr_byte(AW'(0), 8'hFF, 1'b0);
        check("core_mod", 64'(core_mod), 64'h7F);
        wr_byte(AW'(1), 8'h00, 1'b0);
        hps_download = 1'b0;
        tick();
        check("core_mod_hold", 64'(core_mod), 64'h7F);
        tick();

        // NVRAM window
        start(8'd255);
        check("nv_ram_on", 64'(ioctl_ram), 64'd1);
        wr_byte(AW'(32'h10), 8'h5A, 1'b0);
        check("nv_addr", 64'(ioctl_addr), 64'h10);
        check("nv_dout", 64'(ioctl_dout), 64'h5A);
        check("nv_rom_wr", 64'(ioctl_rom_wr), 64'd0);
        hps_download = 1'b0;
        tick();
        check("nv_ram_off", 64'(ioctl_ram), 64'd0);
        tick();

        // reset in the middle of a ROM load
        rom_ack = 1'b0;
        start(8'd0);
        wr_byte(AW'(32'h300), 8'h11, 1'b1);
        wr_byte(AW'(32'h301), 8'h22, 1'b1);
        check("mid_rom_wr", 64'(ioctl_rom_wr), 64'd1);
        rst = 1'b1;
        hps_download = 1'b0;
        sb.delete();
        tick();
        rst = 1'b0;
        check("abort_rom_wr", 64'(ioctl_rom_wr), 64'd0);
        check("abort_dl", 64'(downloading), 64'd0);
        check("abort_dip", 64'(dipsw), 64'd0);
        check("abort_mod", 64'(core_mod), 64'd0);
        check("abort_ovf", 64'(overflow), 64'd0);
        tick();
        // IDLE must accept a fresh ROM load
        start(8'd0);
        check("restart_dl", 64'(downloading), 64'd1);
        hps_download = 1'b0;
        tick();
        tick();
        check("restart_idle", 64'(downloading), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
